// File: rtl/mem_port_arbiter.sv
// Shares one Memoria32 between the up core's fetch and data ports: data-first arbitration
// with a starvation bound for fetch, one access in flight, fixed read latency.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

   state_t     state, state_nxt;
   logic [3:0] starve_cnt, starve_nxt;
   logic [2:0] lat_cnt;
   logic       owner_d;
   logic       grant_if, grant_d;
   logic       grant_rd, grant_wr;
   logic       rd_done;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (state == IDLE) begin
         if (d_req && !(if_req && starve_cnt == STARVE_LIM))
            grant_d = 1'b1;
         else if (if_req)
            grant_if = 1'b1;
      end
   end

   assign grant_rd = grant_if || (grant_d && !d_we);
   assign grant_wr = grant_d && d_we;
   assign rd_done  = (state == RWAIT) && (lat_cnt == 3'd1);

   assign if_gnt = grant_if;
   assign d_gnt  = grant_d;
   assign busy   = (state != IDLE);

   // Fetch has been passed over only if it was actually waiting when data won.
   always_comb begin
      starve_nxt = starve_cnt;
      if (grant_d && if_req) begin
         if (starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
      end else if (grant_d || grant_if) begin
         starve_nxt = '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_wr)
               state_nxt = WRITE;
            else if (grant_rd)
               state_nxt = RWAIT;
         end
         RWAIT: begin
            if (lat_cnt == 3'd1)
               state_nxt = IDLE;
         end
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // nrst is active-high despite its name; being asynchronous, it kills an in-flight access at once.
   // NOTE: state uses non-blocking assignments so every register samples pre-edge values whatever the block order.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         owner_d    <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         if (grant_rd) begin
            lat_cnt <= LAT_INIT;
            owner_d <= grant_d;
         end else if (state == RWAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
         end
      end
   end

   // NOTE: the address/data registers are reset as well, because every output must read 0 straight out of reset.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         mem_raddr <= '0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         mem_wr    <= 1'b0;
      end else begin
         mem_wr <= grant_wr;
         if (grant_rd)
            mem_raddr <= grant_d ? d_addr : if_addr;
         if (grant_wr) begin
            mem_waddr <= d_addr;
            mem_wdata <= d_wdata;
         end
      end
   end

   // Read data registers hold between returns; only the owner of the read sees rvalid.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= rd_done && !owner_d;
         d_rvalid  <= rd_done && owner_d;
         if (rd_done && owner_d)
            d_rdata <= mem_rdata;
         if (rd_done && !owner_d)
            if_rdata <= mem_rdata;
      end
   end

endmodule
